// File: rtl/ex_wb_stage.sv
// Execute stage and EX/WB pipeline register for the 8-bit, 4-stage pipeline.
// Define EX_MUL_EN to build the multi-cycle shift-add multiplier and its upstream stall.
module ex_wb_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] PC_EX,
   input  logic       RegWrite_EX,
   input  logic [3:0] ALU_Operation_EX,
   input  logic [7:0] Read_Data_EX,
   input  logic [7:0] Imm_Data_EX,
   input  logic [7:0] Sht_Data_EX,
   input  logic [2:0] Write_Reg_EX,
   input  logic [1:0] opcode_EX,
   output logic       stall_EX,
   output logic       RegWrite_WB,
   output logic [2:0] Write_Reg_WB,
   output logic [7:0] Write_Data_WB,
   output logic [7:0] PC_WB
);

   logic [2:0] sht;
   logic [7:0] result;
   logic       is_alu;
   logic       unused_sht;

   assign sht        = Sht_Data_EX[2:0];
   assign is_alu     = ~opcode_EX[1];
   assign unused_sht = ^Sht_Data_EX[7:3];

   always_comb begin
      result = 8'h00;
      if (opcode_EX == 2'b10) begin
         result = PC_EX + 8'd1;
      end else if (is_alu) begin
         case (ALU_Operation_EX)
            4'b0000: result = Read_Data_EX + Imm_Data_EX;
            4'b0001: result = Read_Data_EX - Imm_Data_EX;
            4'b0010: result = Read_Data_EX & Imm_Data_EX;
            4'b0011: result = Read_Data_EX | Imm_Data_EX;
            4'b0100: result = Read_Data_EX ^ Imm_Data_EX;
            4'b0101: result = ~Read_Data_EX;
            4'b0110: result = Read_Data_EX << sht;
            4'b0111: result = Read_Data_EX >> sht;
            4'b1000: result = 8'($signed(Read_Data_EX) >>> sht);
            4'b1001: result = Imm_Data_EX;
            default: result = 8'h00;
         endcase
      end
   end

`ifdef EX_MUL_EN
   // state | meaning
   // IDLE  | no multiply pending; a presented MUL is loaded here
   // MUL   | one shift-add step per cycle, 8 steps
   // DONE  | product ready; EX/WB captures it with the held MUL's fields
   typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

   mul_state_t state;
   logic [2:0] count;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [7:0] acc;
   logic       is_mul;

   assign is_mul = is_alu && (ALU_Operation_EX == 4'b1010);
   // Gated by reset so the freeze drops at once even with a MUL still held on the inputs.
   assign stall_EX = reset && (((state == IDLE) && is_mul) || (state == MUL));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= 3'd0;
         a_q   <= 8'h00;
         b_q   <= 8'h00;
         acc   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (is_mul) begin
                  a_q   <= Read_Data_EX;
                  b_q   <= Imm_Data_EX;
                  acc   <= 8'h00;
                  count <= 3'd0;
                  state <= MUL;
               end
            end
            MUL: begin
               if (b_q[0]) acc <= acc + a_q;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
               count <= count + 3'd1;
               if (count == 3'd7) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign stall_EX = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWrite_WB   <= 1'b0;
         Write_Reg_WB  <= 3'd0;
         Write_Data_WB <= 8'h00;
         PC_WB         <= 8'h00;
      end else if (stall_EX) begin
         RegWrite_WB   <= 1'b0;
         Write_Reg_WB  <= 3'd0;
         Write_Data_WB <= 8'h00;
         PC_WB         <= 8'h00;
`ifdef EX_MUL_EN
      end else if (state == DONE) begin
         RegWrite_WB   <= RegWrite_EX;
         Write_Reg_WB  <= Write_Reg_EX;
         Write_Data_WB <= acc;
         PC_WB         <= PC_EX;
`endif
      end else begin
         RegWrite_WB   <= RegWrite_EX && (opcode_EX != 2'b11);
         Write_Reg_WB  <= Write_Reg_EX;
         Write_Data_WB <= result;
         PC_WB         <= PC_EX;
      end
   end

endmodule
